// File: rtl/vga_timing_gen_pkg.sv
// Shared constants for the raster timing generator: mode constant sets
// (640x480@60 default, 800x600@60), sync polarity encodings and a small
// helper that maps an "inside sync" flag onto the configured pin level.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN (frame counter output).
package vga_timing_gen_pkg;

  // Sync polarity encodings: the level the sync pin takes while active.
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // One complete video mode: per-axis segment lengths plus sync polarities.
  typedef struct packed {
    int h_display;
    int h_front;
    int h_sync;
    int h_back;
    int v_display;
    int v_bottom;
    int v_sync;
    int v_top;
    bit h_pol;
    bit v_pol;
  } vga_mode_t;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs.
  localparam vga_mode_t MODE_640X480_60 = '{
    h_display: 640, h_front: 16, h_sync: 96, h_back: 48,
    v_display: 480, v_bottom: 10, v_sync: 2, v_top: 33,
    h_pol: SYNC_ACTIVE_LOW, v_pol: SYNC_ACTIVE_LOW
  };

  // 800x600@60, 40 MHz pixel clock, positive syncs.
  localparam vga_mode_t MODE_800X600_60 = '{
    h_display: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_display: 600, v_bottom: 1, v_sync: 4, v_top: 23,
    h_pol: SYNC_ACTIVE_HIGH, v_pol: SYNC_ACTIVE_HIGH
  };

  // Pin level for a sync signal: the polarity value while active, its
  // complement otherwise.
  function automatic logic sync_level(input logic active, input bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// Generic wrap counter used for both raster axes (module vga_axis_counter).
// Counts 0..max while en is high; wrap flags the enabled step that returns
// the count to zero, so it can directly enable the next axis.
module vga_axis_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == max);
  assign wrap     = en && w_at_max;
  assign cnt      = r_cnt;

  // Advance on en, returning to zero after max.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. Two axis counters track the
// pixel being generated; a decode stage turns (hcnt,vcnt) into sync, blank
// and strobe flags, and one output register bank captures all of them on
// the same pix_ce so every output describes one pixel (latency 1 pix_ce).
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame_cnt
// output that increments in the update that asserts frame_start.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int HW        = 10,
  parameter int VW        = 10,
  parameter int H_DISPLAY = MODE_640X480_60.h_display,
  parameter int H_FRONT   = MODE_640X480_60.h_front,
  parameter int H_SYNC    = MODE_640X480_60.h_sync,
  parameter int H_BACK    = MODE_640X480_60.h_back,
  parameter int V_DISPLAY = MODE_640X480_60.v_display,
  parameter int V_BOTTOM  = MODE_640X480_60.v_bottom,
  parameter int V_SYNC    = MODE_640X480_60.v_sync,
  parameter int V_TOP     = MODE_640X480_60.v_top,
  parameter bit H_POL     = MODE_640X480_60.h_pol,
  parameter bit V_POL     = MODE_640X480_60.v_pol
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          hblank,
  output logic          vblank,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  // One extra bit so the sync end boundary (which may equal 2^HW) fits.
  localparam int HC = HW + 1;
  localparam int VC = VW + 1;

  localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
  localparam logic [HC-1:0] H_DISP_END = HC'(H_DISPLAY);
  localparam logic [HC-1:0] H_SYNC_BEG = HC'(H_DISPLAY + H_FRONT);
  localparam logic [HC-1:0] H_SYNC_END = HC'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VC-1:0] V_DISP_END = VC'(V_DISPLAY);
  localparam logic [VC-1:0] V_SYNC_BEG = VC'(V_DISPLAY + V_BOTTOM);
  localparam logic [VC-1:0] V_SYNC_END = VC'(V_DISPLAY + V_BOTTOM + V_SYNC);

  // Reject geometries the counters cannot represent or that have no sync.
  if (H_TOTAL > (1 << HW)) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL %0d does not fit in HW=%0d bits", H_TOTAL, HW);
  end
  if (V_TOTAL > (1 << VW)) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL %0d does not fit in VW=%0d bits", V_TOTAL, VW);
  end
  if (H_SYNC < 1) begin : g_h_sync_chk
    $error("vga_timing_gen: H_SYNC must be at least 1");
  end
  if (V_SYNC < 1) begin : g_v_sync_chk
    $error("vga_timing_gen: V_SYNC must be at least 1");
  end

  logic [HW-1:0] w_hcnt;
  logic [VW-1:0] w_vcnt;
  logic          w_hwrap;
  logic          w_unused_vwrap;  // end-of-frame step; decode keys off (0,0) instead

  logic w_hsync;
  logic w_vsync;
  logic w_hblank;
  logic w_vblank;
  logic w_display_on;
  logic w_line_start;
  logic w_frame_start;

  logic          r_hsync;
  logic          r_vsync;
  logic          r_display_on;
  logic          r_hblank;
  logic          r_vblank;
  logic [HW-1:0] r_hpos;
  logic [VW-1:0] r_vpos;
  logic          r_line_start;
  logic          r_frame_start;

  vga_axis_counter #(.W(HW)) u_hcnt (
    .clk   (clk),
    .reset (reset),
    .en    (pix_ce),
    .max   (H_MAX),
    .cnt   (w_hcnt),
    .wrap  (w_hwrap)
  );

  // The line counter steps once per completed line.
  vga_axis_counter #(.W(VW)) u_vcnt (
    .clk   (clk),
    .reset (reset),
    .en    (w_hwrap),
    .max   (V_MAX),
    .cnt   (w_vcnt),
    .wrap  (w_unused_vwrap)
  );

  // Decode the pixel the counters currently point at.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_hsync       = ~H_POL;
    w_vsync       = ~V_POL;
    w_hblank      = 1'b0;
    w_vblank      = 1'b0;
    w_display_on  = 1'b0;
    w_line_start  = 1'b0;
    w_frame_start = 1'b0;

    w_hsync  = sync_level(({1'b0, w_hcnt} >= H_SYNC_BEG) && ({1'b0, w_hcnt} < H_SYNC_END), H_POL);
    w_vsync  = sync_level(({1'b0, w_vcnt} >= V_SYNC_BEG) && ({1'b0, w_vcnt} < V_SYNC_END), V_POL);
    w_hblank = ({1'b0, w_hcnt} >= H_DISP_END);
    w_vblank = ({1'b0, w_vcnt} >= V_DISP_END);
    w_display_on  = !w_hblank && !w_vblank;
    w_line_start  = (w_hcnt == '0);
    w_frame_start = w_line_start && (w_vcnt == '0);
  end

  // Capture the whole decoded pixel at once; hold everything while pix_ce=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_display_on  <= 1'b0;
      r_hblank      <= 1'b0;
      r_vblank      <= 1'b0;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_ce) begin
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_display_on  <= w_display_on;
      r_hblank      <= w_hblank;
      r_vblank      <= w_vblank;
      r_hpos        <= w_hcnt;
      r_vpos        <= w_vcnt;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display_on;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count frames in the same update that raises frame_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (pix_ce && w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Three instances share clk/reset:
//  u_def   - default 640x480 geometry, first line inspected in full.
//  u_small - 8/2/3/2 x 4/1/2/1 geometry (15x8), full frames, pix_ce gating,
//            mid-frame reset and (with VGA_TIMING_FRAME_CNT_EN) frame_cnt.
//  u_pol   - active-high syncs with zero porches (6x4).
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic ce_d, ce_s, ce_p;

  int n_chk;
  int n_fail;

  // u_def outputs
  logic       d_hsync, d_vsync, d_disp, d_hblank, d_vblank, d_ls, d_fs;
  logic [9:0] d_hpos, d_vpos;
  // u_small outputs
  logic       s_hsync, s_vsync, s_disp, s_hblank, s_vblank, s_ls, s_fs;
  logic [3:0] s_hpos;
  logic [2:0] s_vpos;
  // u_pol outputs
  logic       p_hsync, p_vsync, p_disp, p_hblank, p_vblank, p_ls, p_fs;
  logic [2:0] p_hpos;
  logic [1:0] p_vpos;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fcnt, s_fcnt, p_fcnt;
`endif

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_n), .pix_ce(ce_d),
    .hsync(d_hsync), .vsync(d_vsync), .display_on(d_disp),
    .hblank(d_hblank), .vblank(d_vblank), .hpos(d_hpos), .vpos(d_vpos),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fcnt)
`endif
  );

  vga_timing_gen #(
    .HW(4), .VW(3),
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(rst_n), .pix_ce(ce_s),
    .hsync(s_hsync), .vsync(s_vsync), .display_on(s_disp),
    .hblank(s_hblank), .vblank(s_vblank), .hpos(s_hpos), .vpos(s_vpos),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fcnt)
`endif
  );

  vga_timing_gen #(
    .HW(3), .VW(2),
    .H_DISPLAY(4), .H_FRONT(0), .H_SYNC(2), .H_BACK(0),
    .V_DISPLAY(3), .V_BOTTOM(0), .V_SYNC(1), .V_TOP(0),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_pol (
    .clk(clk), .reset(rst_n), .pix_ce(ce_p),
    .hsync(p_hsync), .vsync(p_vsync), .display_on(p_disp),
    .hblank(p_hblank), .vblank(p_vblank), .hpos(p_hpos), .vpos(p_vpos),
    .line_start(p_ls), .frame_start(p_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(p_fcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ce_d   = 1'b0;
    ce_s   = 1'b0;
    ce_p   = 1'b0;
    rst_n  = 1'b0;

    // ---- reset state ----
    #12;
    check("rst d_hpos", d_hpos, 0);
    check("rst d_vpos", d_vpos, 0);
    check("rst d_hsync", d_hsync, 1);
    check("rst d_vsync", d_vsync, 1);
    check("rst d_disp", d_disp, 0);
    check("rst d_hblank", d_hblank, 0);
    check("rst d_vblank", d_vblank, 0);
    check("rst d_ls", d_ls, 0);
    check("rst d_fs", d_fs, 0);
    check("rst p_hsync", p_hsync, 0);
    check("rst p_vsync", p_vsync, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("rst s_fcnt", s_fcnt, 0);
`endif

    // ---- default geometry: one full line at pix_ce=1 ----
    @(negedge clk);
    rst_n = 1'b1;
    ce_d  = 1'b1;
    tick();
    check("d first hpos", d_hpos, 0);
    check("d first vpos", d_vpos, 0);
    check("d first disp", d_disp, 1);
    check("d first ls", d_ls, 1);
    check("d first fs", d_fs, 1);
    check("d first hsync", d_hsync, 1);
    for (int i = 1; i < 800; i++) begin
      tick();
      check("d hpos", d_hpos, i);
      check("d hsync", d_hsync, !(i >= 656 && i <= 751));
      check("d ls", d_ls, 0);
      check("d disp", d_disp, (i < 640));
      check("d hblank", d_hblank, (i >= 640));
    end
    tick();
    check("d line2 hpos", d_hpos, 0);
    check("d line2 vpos", d_vpos, 1);
    check("d line2 ls", d_ls, 1);
    check("d line2 fs", d_fs, 0);
    ce_d = 1'b0;

    // ---- small geometry: full frame plus wrap ----
    ce_s = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int h = 0; h < 15; h++) begin
        tick();
        check("s hpos", s_hpos, h);
        check("s vpos", s_vpos, v);
        check("s hsync", s_hsync, !(h >= 10 && h <= 12));
        check("s vsync", s_vsync, !(v >= 5 && v <= 6));
        check("s disp", s_disp, (h < 8 && v < 4));
        check("s vblank", s_vblank, (v >= 4));
        check("s ls", s_ls, (h == 0));
        check("s fs", s_fs, (h == 0 && v == 0));
      end
    end
    tick();
    check("s wrap hpos", s_hpos, 0);
    check("s wrap vpos", s_vpos, 0);
    check("s wrap fs", s_fs, 1);
    check("s wrap disp", s_disp, 1);

    // ---- pix_ce 1-of-4: outputs advance once per strobe, hold otherwise ----
    for (int j = 1; j <= 30; j++) begin
      ce_s = 1'b1;
      tick();
      check("ce4 hpos", s_hpos, j % 15);
      check("ce4 vpos", s_vpos, j / 15);
      check("ce4 ls", s_ls, (j % 15 == 0));
      ce_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("ce4 hold hpos", s_hpos, j % 15);
        check("ce4 hold ls", s_ls, (j % 15 == 0));
      end
    end

    // ---- active-high syncs, zero porches ----
    ce_p = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 6; h++) begin
        tick();
        check("p hpos", p_hpos, h);
        check("p vpos", p_vpos, v);
        check("p hsync", p_hsync, (h >= 4));
        check("p vsync", p_vsync, (v == 3));
        check("p hblank", p_hblank, (h >= 4));
        check("p disp", p_disp, (h < 4 && v < 3));
      end
    end
    tick();
    check("p wrap hpos", p_hpos, 0);
    check("p wrap vpos", p_vpos, 0);
    check("p wrap fs", p_fs, 1);
    ce_p = 1'b0;

    // ---- reset mid-frame, between clock edges ----
    ce_s = 1'b1;
    repeat (5) tick();
    check("pre-rst hpos", s_hpos, 5);
    check("pre-rst vpos", s_vpos, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-rst hpos", s_hpos, 0);
    check("mid-rst vpos", s_vpos, 0);
    check("mid-rst disp", s_disp, 0);
    check("mid-rst hsync", s_hsync, 1);
    check("mid-rst vsync", s_vsync, 1);
    check("mid-rst ls", s_ls, 0);
    check("mid-rst fs", s_fs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post-rst hpos", s_hpos, 0);
    check("post-rst vpos", s_vpos, 0);
    check("post-rst fs", s_fs, 1);
    check("post-rst disp", s_disp, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fcnt first", s_fcnt, 1);
`endif
    tick();
    check("post-rst next hpos", s_hpos, 1);
    check("post-rst next fs", s_fs, 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // ---- frame counter ----
    repeat (119) tick();
    check("fcnt f2 fs", s_fs, 1);
    check("fcnt f2", s_fcnt, 2);
    repeat (120) tick();
    check("fcnt f3", s_fcnt, 3);
    force u_small.r_frame_cnt = 16'hFFFF;
    #1;
    release u_small.r_frame_cnt;
    repeat (120) tick();
    check("fcnt wrap fs", s_fs, 1);
    check("fcnt wrap", s_fcnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
